// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, encodings and access legality check for the MEM-stage LSU
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GNT = 2'd1,
        WAIT_RSP = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

    // Legal size/sign code for the access direction and naturally aligned.
    // Unsigned codes only exist for loads; anything else is dropped as misaligned.
    function automatic logic access_ok(input logic is_store, input logic [2:0] f3,
                                       input logic [1:0] off);
        logic ok;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = !off[0];
            F3_W:    ok = (off == 2'b00);
            F3_BU:   ok = !is_store;
            F3_HU:   ok = !is_store && !off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - lane select and sign/zero extension of a full-word load
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = rdata >> {byte_off, 3'b000};

    // Pick the addressed lane(s) and extend according to the access code
    always_comb begin
        data = '0;
        case (funct3)
            F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    data = shifted;
            F3_BU:   data = {24'd0, shifted[7:0]};
            F3_HU:   data = {16'd0, shifted[15:0]};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM stage load/store unit driving the MEM/WB register
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RegWriteM,
    input  logic [1:0]            ResultSrcM,
    input  logic                  MemWriteM,
    input  logic [2:0]            Funct3M,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic [DATA_WIDTH-1:0] PCPlus4M,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    output logic [3:0]            dmem_be,
    input  logic                  dmem_ready,
    input  logic                  dmem_rvalid,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  StallM,
    output logic                  MisalignM,
    output logic                  RegWriteW,
    output logic [1:0]            ResultSrcW,
    output logic [DATA_WIDTH-1:0] ALUResultW,
    output logic [DATA_WIDTH-1:0] ReadDataW,
    output logic [REG_ADDR_W-1:0] RdW,
    output logic [DATA_WIDTH-1:0] PCPlus4W
);

    lsu_state_t state, state_nxt;

    logic [1:0]            off;
    logic                  is_store;
    logic                  mem_op;
    logic                  legal;
    logic                  misalign;
    logic                  pending;
    logic                  accept;
    logic                  store_done;
    logic                  load_done;
    logic                  retire;
    logic [DATA_WIDTH-1:0] load_data;

    assign off      = ALUResultM[1:0];
    assign is_store = MemWriteM;
    assign mem_op   = MemWriteM | (ResultSrcM == RES_LOAD);
    assign legal    = access_ok(is_store, Funct3M, off);

    // Misalignment is only judged when a new op is presented; once in a wait
    // state the op was already found legal and its inputs are held upstream.
    assign misalign = (state == IDLE) && mem_op && !legal;
    assign pending  = (state != IDLE) || (mem_op && legal);

    // Request is gated by rst_n so it drops the instant reset asserts
    assign dmem_req   = rst_n && (((state == IDLE) && mem_op && legal) || (state == WAIT_GNT));
    assign accept     = dmem_req && dmem_ready;
    assign store_done = accept && is_store;
    assign load_done  = (state == WAIT_RSP) && dmem_rvalid;
    assign retire     = store_done || load_done;
    assign StallM     = rst_n && pending && !retire;

    assign dmem_we   = dmem_req && is_store;
    assign dmem_addr = {ALUResultM[ADDR_WIDTH-1:2], 2'b00};

    // Byte enables and lane-replicated store data; loads always read the full word
    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = WriteDataM;
        if (is_store) begin
            case (Funct3M[1:0])
                2'b00: begin
                    dmem_be    = 4'b0001 << off;
                    dmem_wdata = {4{WriteDataM[7:0]}};
                end
                2'b01: begin
                    dmem_be    = 4'b0011 << off;
                    dmem_wdata = {2{WriteDataM[15:0]}};
                end
                default: begin
                    dmem_be    = 4'b1111;
                    dmem_wdata = WriteDataM;
                end
            endcase
        end
    end

    // Next-state: request in IDLE/WAIT_GNT until accepted, then wait for load data
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (mem_op && legal) begin
                    if (!dmem_ready)   state_nxt = WAIT_GNT;
                    else if (!is_store) state_nxt = WAIT_RSP;
                end
            end
            WAIT_GNT: begin
                if (dmem_ready) state_nxt = is_store ? IDLE : WAIT_RSP;
            end
            WAIT_RSP: begin
                if (dmem_rvalid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Access state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    load_align u_load_align (
        .rdata    (dmem_rdata),
        .funct3   (Funct3M),
        .byte_off (off),
        .data     (load_data)
    );

    // MEM/WB register: pass-through for non-memory ops, bubble until a mem op retires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= RES_ALU;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            RdW        <= '0;
            PCPlus4W   <= '0;
            MisalignM  <= 1'b0;
        end else begin
            ResultSrcW <= ResultSrcM;
            ALUResultW <= ALUResultM;
            RdW        <= RdM;
            PCPlus4W   <= PCPlus4M;
            MisalignM  <= misalign;
            if (!pending && !misalign) begin
                RegWriteW <= RegWriteM;
            end else if (load_done) begin
                RegWriteW <= RegWriteM;
                ReadDataW <= load_data;
            end else begin
                RegWriteW <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - self-checking bench for mem_stage_lsu
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        StallM, MisalignM, RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
    logic [4:0]  RdW;

    always #5 clk = ~clk;

    mem_stage_lsu dut (
        .clk(clk), .rst_n(rst_n),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .RdM(RdM), .PCPlus4M(PCPlus4M),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .StallM(StallM), .MisalignM(MisalignM),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
        .ReadDataW(ReadDataW), .RdW(RdW), .PCPlus4W(PCPlus4W)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Expected combinational outputs for the current cycle
    logic        e_req, e_stall, e_we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    // Expected registered outputs now (e_) and after the coming edge (n_)
    logic        e_regw, e_mis, e_fields, e_rdv, n_regw, n_mis, n_fields, n_rdv;
    logic [31:0] e_alu, e_pc4, e_rdw, n_alu, n_pc4, n_rdw;
    logic [4:0]  e_rd, n_rd;
    logic [1:0]  e_rs, n_rs;
    logic        chk_en = 1'b0;
    int          stall_cnt, req_cnt;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata;

    function automatic logic f_bad(input logic mw, input logic [2:0] f3, input logic [1:0] a);
        logic legal;
        int   size;
        if (mw) legal = (f3 <= 3'd2);
        else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        size = 1 << f3[1:0];
        return !legal || ((int'(a) % size) != 0);
    endfunction

    function automatic logic [3:0] f_be(input logic ld, input logic [2:0] f3, input logic [1:0] a);
        int size, mask;
        if (ld) return 4'hF;
        size = 1 << f3[1:0];
        mask = ((1 << size) - 1) << a;
        return mask[3:0];
    endfunction

    function automatic logic [31:0] f_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'd0:    return {4{wd[7:0]}};
            2'd1:    return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] rd);
        longint size, v;
        size = (f3[1:0] == 2'd2) ? 4 : (1 << f3[1:0]);
        v = (longint'(rd) >> (8 * a)) & ((64'd1 << (8 * size)) - 1);
        if (!f3[2] && size < 4 && v >= (64'd1 << (8 * size - 1)))
            v = v - (64'd1 << (8 * size));
        return v[31:0];
    endfunction

    // Compare DUT outputs against the model once per cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req", dmem_req, e_req);
            chk("stall", StallM, e_stall);
            chk("misalign", MisalignM, e_mis);
            chk("regwrite_w", RegWriteW, e_regw);
            if (e_req) begin
                chk("addr", dmem_addr, e_addr);
                chk("be", dmem_be, e_be);
                chk("we", dmem_we, e_we);
                if (e_we) chk("wdata", dmem_wdata, e_wdata);
            end
            if (e_fields) begin
                chk("alu_w", ALUResultW, e_alu);
                chk("rd_w", RdW, e_rd);
                chk("pc4_w", PCPlus4W, e_pc4);
                chk("ressrc_w", ResultSrcW, e_rs);
            end
            if (e_rdv) chk("readdata_w", ReadDataW, e_rdw);
            if (StallM) stall_cnt++;
            if (dmem_req) begin
                req_cnt++;
                cap_be    = dmem_be;
                cap_wdata = dmem_wdata;
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        e_regw = n_regw; e_mis = n_mis; e_fields = n_fields; e_rdv = n_rdv;
        e_alu = n_alu; e_pc4 = n_pc4; e_rdw = n_rdw; e_rd = n_rd; e_rs = n_rs;
    endtask

    // One EX/MEM op; g = cycles ready stays low, r = cycles from accept to rvalid
    task automatic do_op(input logic rw, input logic [1:0] rs, input logic mw, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                         input logic [31:0] pc4, input int g, input int r, input logic [31:0] rdata);
        logic memop;
        RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw; Funct3M = f3;
        ALUResultM = alu; WriteDataM = wd; RdM = rd; PCPlus4M = pc4;
        stall_cnt = 0; req_cnt = 0;
        memop = mw || (rs == 2'b01);
        n_alu = alu; n_rd = rd; n_pc4 = pc4; n_rs = rs;
        e_addr = alu & 32'hFFFF_FFFC;
        e_be = f_be(!mw, f3, alu[1:0]);
        e_we = mw;
        e_wdata = f_wdata(f3, wd);
        if (!memop) begin
            dmem_ready = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
            e_req = 1'b0; e_stall = 1'b0;
            n_regw = rw; n_mis = 1'b0; n_fields = 1'b1; n_rdv = 1'b0;
            cycle();
        end else if (f_bad(mw, f3, alu[1:0])) begin
            dmem_ready = 1'b1; dmem_rvalid = 1'b1;
            e_req = 1'b0; e_stall = 1'b0;
            n_regw = 1'b0; n_mis = 1'b1; n_fields = 1'b0; n_rdv = 1'b0;
            cycle();
        end else begin
            for (int i = 0; i <= g; i++) begin
                dmem_ready = (i == g); dmem_rvalid = 1'b1; dmem_rdata = 32'h5A5A_5A5A;
                e_req = 1'b1; e_stall = !(mw && i == g);
                n_regw = 1'b0; n_mis = 1'b0; n_fields = 1'b0; n_rdv = 1'b0;
                cycle();
            end
            if (!mw) begin
                for (int j = 1; j <= r; j++) begin
                    dmem_ready = 1'b1; dmem_rvalid = (j == r);
                    dmem_rdata = (j == r) ? rdata : ~rdata;
                    e_req = 1'b0; e_stall = (j != r);
                    n_regw = (j == r) ? rw : 1'b0;
                    n_rdw = f_load(f3, alu[1:0], rdata);
                    n_rdv = (j == r); n_fields = (j == r); n_mis = 1'b0;
                    cycle();
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        RegWriteM = 0; ResultSrcM = 0; MemWriteM = 0; Funct3M = 0;
        ALUResultM = 0; WriteDataM = 0; RdM = 0; PCPlus4M = 0;
        dmem_ready = 0; dmem_rvalid = 0; dmem_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_regw", RegWriteW, 0);
        chk("rst_alu", ALUResultW, 0);
        chk("rst_rdata", ReadDataW, 0);
        chk("rst_rd", RdW, 0);
        chk("rst_pc4", PCPlus4W, 0);
        chk("rst_ressrc", ResultSrcW, 0);
        chk("rst_mis", MisalignM, 0);
        chk("rst_stall", StallM, 0);
        chk("rst_req", dmem_req, 0);
        rst_n = 1'b1;
        n_regw = 0; n_mis = 0; n_fields = 1; n_rdv = 0;
        n_alu = 0; n_pc4 = 0; n_rdw = 0; n_rd = 0; n_rs = 0;
        e_regw = 0; e_mis = 0; e_fields = 1; e_rdv = 0;
        e_alu = 0; e_pc4 = 0; e_rdw = 0; e_rd = 0; e_rs = 0;
        e_req = 0; e_stall = 0; e_we = 0; e_addr = 0; e_be = 0; e_wdata = 0;
        chk_en = 1'b1;

        // ADD result passes straight through
        do_op(1, 2'b00, 0, 3'b000, 32'h1234, 32'h0, 5'd5, 32'h104, 0, 0, 0);
        chk("t1_regw", RegWriteW, 1);
        chk("t1_alu", ALUResultW, 32'h1234);
        chk("t1_rd", RdW, 5);
        chk("t1_stall", stall_cnt, 0);

        // SB to top lane, immediate grant
        do_op(0, 2'b00, 1, 3'b000, 32'h103, 32'hAB, 5'd0, 32'h108, 0, 0, 0);
        chk("t2_be", cap_be, 4'b1000);
        chk("t2_wdata", cap_wdata, 32'hABAB_ABAB);
        chk("t2_stall", stall_cnt, 0);
        chk("t2_req_cycles", req_cnt, 1);
        chk("t2_regw", RegWriteW, 0);

        // LB, zero-wait memory, back to back with the store
        do_op(1, 2'b01, 0, 3'b000, 32'h102, 32'h0, 5'd7, 32'h10C, 0, 1, 32'h0080_0000);
        chk("t3_stall", stall_cnt, 1);
        chk("t3_rdata", ReadDataW, 32'hFFFF_FF80);
        chk("t3_regw", RegWriteW, 1);

        // LHU with slow grant and slow response
        do_op(1, 2'b01, 0, 3'b101, 32'h102, 32'h0, 5'd8, 32'h110, 3, 2, 32'h8001_0000);
        chk("t4_stall", stall_cnt, 5);
        chk("t4_rdata", ReadDataW, 32'h0000_8001);
        chk("t4_req_cycles", req_cnt, 4);

        // Misaligned LW is dropped
        do_op(1, 2'b01, 0, 3'b010, 32'h101, 32'h0, 5'd9, 32'h114, 0, 1, 32'h1111_1111);
        chk("t5_req_cycles", req_cnt, 0);
        chk("t5_stall", stall_cnt, 0);
        chk("t5_mis", MisalignM, 1);
        chk("t5_regw", RegWriteW, 0);

        // Further patterns checked by the model
        do_op(0, 2'b00, 1, 3'b001, 32'h102, 32'h1234_ABCD, 5'd0, 32'h118, 1, 0, 0);
        chk("sh_be", cap_be, 4'b1100);
        chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
        do_op(0, 2'b00, 1, 3'b010, 32'h200, 32'hCAFE_F00D, 5'd0, 32'h11C, 0, 0, 0);
        do_op(1, 2'b01, 0, 3'b001, 32'h100, 32'h0, 5'd10, 32'h120, 0, 1, 32'h0000_FFFE);
        chk("lh_rdata", ReadDataW, 32'hFFFF_FFFE);
        do_op(1, 2'b01, 0, 3'b100, 32'h101, 32'h0, 5'd11, 32'h124, 2, 3, 32'h0000_AB00);
        chk("lbu_rdata", ReadDataW, 32'h0000_00AB);
        do_op(1, 2'b01, 0, 3'b010, 32'h104, 32'h0, 5'd12, 32'h128, 0, 1, 32'h1357_9BDF);
        do_op(1, 2'b01, 0, 3'b011, 32'h100, 32'h0, 5'd13, 32'h12C, 0, 1, 32'h0);
        do_op(0, 2'b00, 1, 3'b001, 32'h101, 32'hFFFF, 5'd0, 32'h130, 0, 0, 0);
        do_op(0, 2'b00, 1, 3'b100, 32'h100, 32'hFFFF, 5'd0, 32'h134, 0, 0, 0);
        do_op(1, 2'b10, 0, 3'b000, 32'h55, 32'h0, 5'd1, 32'h400, 0, 0, 0);
        do_op(1, 2'b01, 0, 3'b000, 32'h103, 32'h0, 5'd14, 32'h138, 1, 1, 32'h7F00_0000);
        chk("lb_pos_rdata", ReadDataW, 32'h0000_007F);
        do_op(0, 2'b00, 1, 3'b000, 32'h101, 32'h12, 5'd0, 32'h13C, 0, 0, 0);
        chk("sb1_be", cap_be, 4'b0010);
        chk_en = 1'b0;

        // Reset asserted while a load waits for its response
        RegWriteM = 1; ResultSrcM = 2'b01; MemWriteM = 0; Funct3M = 3'b010;
        ALUResultM = 32'h108; RdM = 5'd3;
        dmem_ready = 1'b1; dmem_rvalid = 1'b0;
        @(posedge clk);
        #1;
        dmem_ready = 1'b0;
        #1;
        chk("t6_stall_before", StallM, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_req", dmem_req, 0);
        chk("t6_stall", StallM, 0);
        chk("t6_regw", RegWriteW, 0);
        chk("t6_alu", ALUResultW, 0);
        chk("t6_rdata", ReadDataW, 0);
        RegWriteM = 0; ResultSrcM = 0; Funct3M = 0; ALUResultM = 0; RdM = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        chk("t6_stale_regw", RegWriteW, 0);
        chk("t6_stale_rdata", ReadDataW, 0);
        chk("t6_idle_stall", StallM, 0);
        chk("t6_idle_req", dmem_req, 0);
        dmem_rvalid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
